hdlc_rx_deframer: RTL and testbench

//  Bit-level HDLC receive front end. Samples serial Rx, detects flag (0x7E) and abort (0x7F) patterns,

---
 rtl/hdlc_rx_deframer_pkg.sv | 8 +
 rtl/hdlc_rx_deframer_if.sv | 25 ++
 rtl/hdlc_rx_deframer_pattern_det.sv | 26 ++
 rtl/hdlc_rx_deframer.sv | 118 +++++++++++
 tb/tb_hdlc_rx_deframer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hdlc_rx_deframer_pkg.sv
// hdlc_rx_deframer_pkg: line patterns, stuffing limit and receive state encoding
package hdlc_rx_deframer_pkg;
  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam logic [7:0] ABORT_PATTERN = 8'h7F;
  localparam logic [2:0] MAX_ONES = 3'd5;
  localparam logic [2:0] FLAG_FLUSH = 3'd7;
  typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;
endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// hdlc_rx_deframer_if: serial line and enable in, frame strobes, status and bytes out
interface hdlc_rx_deframer_if #(parameter int FRAME_CNT_W = 8);
  logic Rx;
  logic RxEN;
  logic RxD;
  logic Rx_FlagDetect;
  logic Rx_AbortDetect;
  logic Rx_ValidFrame;
  logic Rx_NewByte;
  logic [7:0] Rx_Data;
  logic Rx_EoF;
  logic Rx_FrameError;
  logic Rx_AbortSignal;
  logic [FRAME_CNT_W-1:0] Rx_FrameSize;
  modport master (
    output Rx, RxEN,
    input RxD, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_Data,
    input Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_FrameSize
  );
  modport slave (
    input Rx, RxEN,
    output RxD, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_Data,
    output Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_FrameSize
  );
endinterface

// File: rtl/hdlc_rx_deframer_pattern_det.sv
// hdlc_rx_deframer_pattern_det: input register, 8-bit line history and flag/abort match
module hdlc_rx_deframer_pattern_det
  import hdlc_rx_deframer_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic rx,
  output logic rxd,
  output logic bit_out,
  output logic flag_m,
  output logic abort_m
);
  logic [7:0] sr;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rxd <= 1'b1;
      sr <= 8'hFF;
    end else begin
      rxd <= rx;
      sr <= {sr[6:0], rxd};
    end
  end
  assign bit_out = sr[7];
  assign flag_m = sr == FLAG_PATTERN;
  assign abort_m = sr == ABORT_PATTERN;
endmodule

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: frame FSM, zero removal and LSB-first byte assembly behind the pattern detector
module hdlc_rx_deframer
  import hdlc_rx_deframer_pkg::*;
#(
  parameter int FRAME_CNT_W = 8
) (
  input logic Clk,
  input logic Rst,
  hdlc_rx_deframer_if.slave rx
);
  rx_state_t state;
  logic rxd, bit_in, flag_m, abort_m;
  logic abort_pend, commit, drop;
  logic [2:0] skip, ones, bit_cnt;
  logic [7:0] asm_r, data;
  logic [FRAME_CNT_W-1:0] byte_cnt, frame_size;
  logic flag_det, abort_det, new_byte, eof, frame_err, abort_sig;
  hdlc_rx_deframer_pattern_det u_det (
    .Clk(Clk),
    .Rst(Rst),
    .rx(rx.Rx),
    .rxd(rxd),
    .bit_out(bit_in),
    .flag_m(flag_m),
    .abort_m(abort_m)
  );
  // the bit leaving the history is data only inside a frame, past the opening flag, and not part of a pattern
  always_comb begin
    commit = state == RX_FRAME && skip == 3'd0 && !abort_pend && !flag_m && !abort_m;
    drop = commit && !bit_in && ones == MAX_ONES;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RX_IDLE;
      abort_pend <= 1'b0;
      skip <= 3'd0;
      ones <= 3'd0;
      bit_cnt <= 3'd0;
      byte_cnt <= '0;
      asm_r <= 8'h00;
      data <= 8'h00;
      frame_size <= '0;
      flag_det <= 1'b0;
      abort_det <= 1'b0;
      new_byte <= 1'b0;
      eof <= 1'b0;
      frame_err <= 1'b0;
      abort_sig <= 1'b0;
    end else begin
      flag_det <= 1'b0;
      abort_det <= 1'b0;
      new_byte <= 1'b0;
      eof <= 1'b0;
      frame_err <= 1'b0;
      abort_sig <= 1'b0;
      if (!rx.RxEN) begin
        state <= RX_IDLE;
        abort_pend <= 1'b0;
        skip <= 3'd0;
        ones <= 3'd0;
        bit_cnt <= 3'd0;
        byte_cnt <= '0;
      end else begin
        flag_det <= flag_m;
        abort_det <= abort_m;
        if (skip != 3'd0) skip <= skip - 3'd1;
        if (drop) ones <= 3'd0;
        else if (commit) begin
          ones <= bit_in ? (ones == 3'd7 ? ones : ones + 3'd1) : 3'd0;
          asm_r <= {bit_in, asm_r[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data <= {bit_in, asm_r[7:1]};
            new_byte <= 1'b1;
            byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + FRAME_CNT_W'(1);
          end
        end
        if (state == RX_IDLE) begin
          if (flag_m) begin
            state <= RX_FRAME;
            skip <= FLAG_FLUSH;
            ones <= 3'd0;
            bit_cnt <= 3'd0;
            byte_cnt <= '0;
          end
        end else if (abort_pend) begin
          state <= RX_IDLE;
          abort_pend <= 1'b0;
          abort_sig <= 1'b1;
          eof <= 1'b1;
          frame_size <= byte_cnt;
        end else if (abort_m) abort_pend <= 1'b1;
        else if (flag_m) begin
          // an empty frame so far means this flag just repeats the opener
          if (skip != 3'd0 || (bit_cnt == 3'd0 && byte_cnt == '0)) begin
            skip <= FLAG_FLUSH;
            ones <= 3'd0;
          end else begin
            state <= RX_IDLE;
            eof <= 1'b1;
            frame_err <= bit_cnt != 3'd0;
            frame_size <= byte_cnt;
          end
        end
      end
    end
  end
  assign rx.RxD = rxd;
  assign rx.Rx_ValidFrame = state == RX_FRAME;
  assign rx.Rx_FlagDetect = flag_det;
  assign rx.Rx_AbortDetect = abort_det;
  assign rx.Rx_NewByte = new_byte;
  assign rx.Rx_Data = data;
  assign rx.Rx_EoF = eof;
  assign rx.Rx_FrameError = frame_err;
  assign rx.Rx_AbortSignal = abort_sig;
  assign rx.Rx_FrameSize = frame_size;
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: directed and random frames checked against a bit-stuffing frame model
module tb_hdlc_rx_deframer;
  import hdlc_rx_deframer_pkg::*;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  hdlc_rx_deframer_if #(.FRAME_CNT_W(8)) rx ();
  hdlc_rx_deframer #(.FRAME_CNT_W(8)) dut (.Clk(Clk), .Rst(Rst), .rx(rx));
  int checks = 0;
  int passed = 0;
  int eof_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] got_bytes[$];
  logic last_ferr;
  logic [7:0] last_size;
  bit data_bits[$];
  bit line_bits[$];
  logic [7:0] exp_bytes[$];
  always @(negedge Clk) begin
    if (!Rst) begin
      if (rx.Rx_NewByte) got_bytes.push_back(rx.Rx_Data);
      if (rx.Rx_EoF) begin
        eof_cnt++;
        last_ferr = rx.Rx_FrameError;
        last_size = rx.Rx_FrameSize;
      end
      if (rx.Rx_AbortSignal) abort_cnt++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send_bit(input bit b);
    @(negedge Clk);
    rx.Rx = b;
  endtask
  task automatic send_flag();
    for (int i = 7; i >= 0; i--) send_bit(FLAG_PATTERN[i]);
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask
  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) data_bits.push_back(b[i]);
  endtask
  // transmitter view: a zero follows every run of five ones
  task automatic build_line();
    int run = 0;
    line_bits.delete();
    foreach (data_bits[i]) begin
      line_bits.push_back(data_bits[i]);
      run = data_bits[i] ? run + 1 : 0;
      if (run == 5) begin
        line_bits.push_back(1'b0);
        run = 0;
      end
    end
  endtask
  task automatic run_frame(input int nflags, input bit lat);
    int nb0, e0, nbits;
    logic [7:0] v;
    build_line();
    nb0 = got_bytes.size();
    e0 = eof_cnt;
    for (int k = 0; k < nflags; k++) send_flag();
    foreach (line_bits[i]) begin
      send_bit(line_bits[i]);
      if (lat && i < 3) begin
        check("flag_det_latency", rx.Rx_FlagDetect, i == 2);
        check("valid_latency", rx.Rx_ValidFrame, i == 2);
      end
    end
    send_flag();
    repeat (6) send_bit(1'b1);
    nbits = data_bits.size();
    exp_bytes.delete();
    for (int b = 0; b + 8 <= nbits; b += 8) begin
      for (int j = 0; j < 8; j++) v[j] = data_bits[b + j];
      exp_bytes.push_back(v);
    end
    check("byte_count", got_bytes.size() - nb0, exp_bytes.size());
    foreach (exp_bytes[j]) if (nb0 + j < got_bytes.size()) check("byte_data", got_bytes[nb0 + j], exp_bytes[j]);
    check("eof_count", eof_cnt - e0, 1);
    check("frame_error", last_ferr, (nbits % 8) != 0);
    check("frame_size", last_size, nbits / 8);
    data_bits.delete();
  endtask
  initial begin
    int n, e0, a0;
    rx.Rx = 1'b1;
    rx.RxEN = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_rxd", rx.RxD, 1);
    check("rst_valid", rx.Rx_ValidFrame, 0);
    check("rst_flag_det", rx.Rx_FlagDetect, 0);
    check("rst_new_byte", rx.Rx_NewByte, 0);
    check("rst_data", rx.Rx_Data, 0);
    check("rst_eof", rx.Rx_EoF, 0);
    check("rst_size", rx.Rx_FrameSize, 0);
    check("rst_abort_sig", rx.Rx_AbortSignal, 0);
    Rst = 1'b0;
    repeat (10) send_bit(1'b1);
    add_byte(8'hA5);
    add_byte(8'h3C);
    run_frame(1, 1'b1);
    add_byte(8'hFF);
    run_frame(1, 1'b0);
    add_byte(8'h81);
    run_frame(3, 1'b0);
    add_byte(8'hFF);
    add_byte(8'h7E);
    add_byte(8'h7F);
    run_frame(1, 1'b0);
    repeat (6) begin
      n = $urandom_range(1, 5);
      repeat (n) add_byte(8'($urandom_range(0, 255)));
      run_frame(1, 1'b0);
    end
    repeat (12) data_bits.push_back(1'($urandom_range(0, 1)));
    run_frame(1, 1'b0);
    repeat (3) begin
      n = $urandom_range(9, 30);
      if (n % 8 == 0) n++;
      repeat (n) data_bits.push_back(1'($urandom_range(0, 1)));
      run_frame(1, 1'b0);
    end
    a0 = abort_cnt;
    send_flag();
    send_byte(8'h55);
    send_bit(1'b0);
    repeat (7) send_bit(1'b1);
    repeat (3) send_bit(1'b1);
    check("abort_det", rx.Rx_AbortDetect, 1);
    check("abort_valid_held", rx.Rx_ValidFrame, 1);
    check("abort_sig_early", rx.Rx_AbortSignal, 0);
    send_bit(1'b1);
    check("abort_sig", rx.Rx_AbortSignal, 1);
    check("abort_eof", rx.Rx_EoF, 1);
    check("abort_valid_drop", rx.Rx_ValidFrame, 0);
    check("abort_size", rx.Rx_FrameSize, 1);
    check("abort_data", rx.Rx_Data, 8'h55);
    repeat (4) send_bit(1'b1);
    check("abort_count", abort_cnt - a0, 1);
    e0 = eof_cnt;
    send_flag();
    send_byte(8'h12);
    repeat (10) send_bit(1'b0);
    @(negedge Clk);
    check("en_valid_before", rx.Rx_ValidFrame, 1);
    rx.RxEN = 1'b0;
    @(negedge Clk);
    check("en_valid_drop", rx.Rx_ValidFrame, 0);
    check("en_data_hold", rx.Rx_Data, 8'h12);
    check("en_size_hold", rx.Rx_FrameSize, 1);
    rx.RxEN = 1'b1;
    repeat (10) send_bit(1'b1);
    check("en_no_eof", eof_cnt - e0, 0);
    e0 = eof_cnt;
    send_flag();
    send_byte(8'hC3);
    repeat (10) send_bit(1'b0);
    @(negedge Clk);
    check("mid_data_before", rx.Rx_Data, 8'hC3);
    Rst = 1'b1;
    rx.Rx = 1'b1;
    @(negedge Clk);
    check("mid_rst_data", rx.Rx_Data, 0);
    check("mid_rst_size", rx.Rx_FrameSize, 0);
    check("mid_rst_valid", rx.Rx_ValidFrame, 0);
    check("mid_rst_rxd", rx.RxD, 1);
    check("mid_rst_eof", rx.Rx_EoF, 0);
    Rst = 1'b0;
    repeat (4) send_bit(1'b1);
    check("mid_rst_no_eof", eof_cnt - e0, 0);
    add_byte(8'($urandom_range(0, 255)));
    add_byte(8'h3E);
    run_frame(2, 1'b0);
    check("idle_aborts_silent", abort_cnt, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
